// File: rtl/bipbip_pkg.sv
// -----------------------------------------------------------------------------
// bipbip_pkg
// Shared constants and types for the BipBip pointer-decryption datapath.
//   BIPBIP_TWEAK_W / BIPBIP_BLOCK_W : default tweak and block widths
//   bipbip_cache_state_e            : control states of the decryption memo cache
// -----------------------------------------------------------------------------
package bipbip_pkg;

  localparam int unsigned BIPBIP_TWEAK_W = 64;
  localparam int unsigned BIPBIP_BLOCK_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // waiting for a lookup request
    ST_CHECK = 3'd1,  // comparing the captured pair against all entries
    ST_ISSUE = 3'd2,  // miss: presenting the pair to the decryption core
    ST_WAIT  = 3'd3,  // waiting for the core result pulse
    ST_RESP  = 3'd4   // holding the response until it is consumed
  } bipbip_cache_state_e;

endpackage : bipbip_pkg

// File: rtl/bipbip_lru_age.sv
// -----------------------------------------------------------------------------
// bipbip_lru_age
// Age-based LRU tracker for ENTRIES cache slots. Ages form a permutation of
// 0..ENTRIES-1; age 0 is most recently used, the maximum age is the victim.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (ages <- index)
//   touch_valid_i   mark touch_idx_i as most recently used this cycle
//   touch_idx_i     slot being touched
//   victim_idx_o    slot with the maximum age (decoded from registered ages)
// -----------------------------------------------------------------------------
module bipbip_lru_age #(
  parameter  int unsigned ENTRIES = 4,
  localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             touch_valid_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  output logic [IDX_W-1:0] victim_idx_o
);

  logic [IDX_W-1:0] age_q [ENTRIES];
  logic [IDX_W-1:0] age_d [ENTRIES];
  logic [IDX_W-1:0] old_age;
  logic [IDX_W-1:0] max_age;

  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    old_age = age_q[touch_idx_i];
    for (int i = 0; i < int'(ENTRIES); i++) begin
      age_d[i] = age_q[i];
      if (touch_valid_i) begin
        // Only entries younger than the touched one age; older ones keep
        // their value, which preserves the permutation.
        if (IDX_W'(i) == touch_idx_i) begin
          age_d[i] = '0;
        end else if (age_q[i] < old_age) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim_idx_o = '0;
    max_age      = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (age_q[i] > max_age) begin
        max_age      = age_q[i];
        victim_idx_o = IDX_W'(i);
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(ENTRIES); i++) age_q[i] <= IDX_W'(i);
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) age_q[i] <= age_d[i];
    end
  end

endmodule : bipbip_lru_age

// File: rtl/bipbip_dec_cache.sv
// -----------------------------------------------------------------------------
// bipbip_dec_cache
// Multi-entry memo cache in front of the BipBip decryption core. A lookup that
// matches a valid (tweak, ciphertext) entry is answered from the cache; a miss
// is forwarded to the core and its result fills an LRU-selected entry.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   flush_i                             invalidate all entries (key reload)
//   req_valid_i/req_ready_o             lookup handshake; req_tweak_i, req_ct_i
//   rsp_valid_o/rsp_ready_i             response handshake; rsp_pt_o, rsp_hit_o
//   core_req_valid_o/core_req_ready_i   miss request; core_tweak_o, core_ct_o
//   core_rsp_valid_i, core_pt_i         single-cycle core result
//   hit_cnt_o, miss_cnt_o               saturating statistics
// -----------------------------------------------------------------------------
module bipbip_dec_cache
  import bipbip_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned TWEAK_W = BIPBIP_TWEAK_W,
  parameter int unsigned BLOCK_W = BIPBIP_BLOCK_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [TWEAK_W-1:0] req_tweak_i,
  input  logic [BLOCK_W-1:0] req_ct_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [BLOCK_W-1:0] rsp_pt_o,
  output logic               rsp_hit_o,
  output logic               core_req_valid_o,
  input  logic               core_req_ready_i,
  output logic [TWEAK_W-1:0] core_tweak_o,
  output logic [BLOCK_W-1:0] core_ct_o,
  input  logic               core_rsp_valid_i,
  input  logic [BLOCK_W-1:0] core_pt_i,
  output logic [CNT_W-1:0]   hit_cnt_o,
  output logic [CNT_W-1:0]   miss_cnt_o
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic               valid;
    logic [TWEAK_W-1:0] tweak;
    logic [BLOCK_W-1:0] ct;
    logic [BLOCK_W-1:0] pt;
  } entry_t;

  bipbip_cache_state_e state_q, state_d;
  logic [TWEAK_W-1:0]  req_tweak_q, req_tweak_d;
  logic [BLOCK_W-1:0]  req_ct_q, req_ct_d;
  logic [BLOCK_W-1:0]  rsp_pt_q, rsp_pt_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic                flush_seen_q, flush_seen_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  entry_t              entries_q [ENTRIES];

  logic                hit_any;
  logic [IDX_W-1:0]    hit_idx;
  logic                inv_any;
  logic [IDX_W-1:0]    inv_idx;
  logic [IDX_W-1:0]    lru_victim;
  logic [IDX_W-1:0]    victim_idx;
  logic                touch_valid;
  logic [IDX_W-1:0]    touch_idx;
  logic                fill_en;

  // Tag match against the captured request. Duplicate entries cannot exist,
  // so the last match found is the only one.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (entries_q[i].valid && entries_q[i].tweak == req_tweak_q &&
          entries_q[i].ct == req_ct_q) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Empty slots are filled first (lowest index wins); only a full cache
  // falls back to the LRU victim.
  always_comb begin
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        inv_any = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
    victim_idx = inv_any ? inv_idx : lru_victim;
  end

  bipbip_lru_age #(
    .ENTRIES (ENTRIES)
  ) u_lru_age (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .touch_valid_i (touch_valid),
    .touch_idx_i   (touch_idx),
    .victim_idx_o  (lru_victim)
  );

  always_comb begin
    state_d      = state_q;
    req_tweak_d  = req_tweak_q;
    req_ct_d     = req_ct_q;
    rsp_pt_d     = rsp_pt_q;
    rsp_hit_d    = rsp_hit_q;
    flush_seen_d = flush_seen_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    touch_valid  = 1'b0;
    touch_idx    = '0;
    fill_en      = 1'b0;

    // A flush seen anywhere between CHECK and the core result means the
    // result belongs to the old key and must not be cached.
    if (state_q != ST_IDLE && flush_i) flush_seen_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        flush_seen_d = 1'b0;
        if (req_valid_i) begin
          req_tweak_d = req_tweak_i;
          req_ct_d    = req_ct_i;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hit_any && !flush_i) begin
          rsp_pt_d    = entries_q[hit_idx].pt;
          rsp_hit_d   = 1'b1;
          touch_valid = 1'b1;
          touch_idx   = hit_idx;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
          state_d     = ST_RESP;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_req_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_rsp_valid_i) begin
          rsp_pt_d  = core_pt_i;
          rsp_hit_d = 1'b0;
          if (!flush_i && !flush_seen_q) begin
            fill_en     = 1'b1;
            touch_valid = 1'b1;
            touch_idx   = victim_idx;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      req_tweak_q  <= '0;
      req_ct_q     <= '0;
      rsp_pt_q     <= '0;
      rsp_hit_q    <= 1'b0;
      flush_seen_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_tweak_q  <= req_tweak_d;
      req_ct_q     <= req_ct_d;
      rsp_pt_q     <= rsp_pt_d;
      rsp_hit_q    <= rsp_hit_d;
      flush_seen_q <= flush_seen_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // NOTE: only the valid bits are reset; the tweak/ct/pt payload is never
  // read while its valid bit is clear, so it is left without a reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(ENTRIES); i++) entries_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (flush_i) begin
          entries_q[i].valid <= 1'b0;
        end else if (fill_en && victim_idx == IDX_W'(i)) begin
          entries_q[i] <= '{valid: 1'b1, tweak: req_tweak_q, ct: req_ct_q, pt: core_pt_i};
        end
      end
    end
  end

  assign req_ready_o      = (state_q == ST_IDLE);
  assign rsp_valid_o      = (state_q == ST_RESP);
  assign core_req_valid_o = (state_q == ST_ISSUE);
  assign rsp_pt_o         = rsp_pt_q;
  assign rsp_hit_o        = rsp_hit_q;
  assign core_tweak_o     = req_tweak_q;
  assign core_ct_o        = req_ct_q;
  assign hit_cnt_o        = hit_cnt_q;
  assign miss_cnt_o       = miss_cnt_q;

endmodule : bipbip_dec_cache

// File: tb/tb_bipbip_dec_cache.sv
// -----------------------------------------------------------------------------
// tb_bipbip_dec_cache
// Directed bench for bipbip_dec_cache. Two instances share all inputs: the main
// one (ENTRIES=4, CNT_W=16) and a CNT_W=2 copy whose counters must saturate at 3.
// -----------------------------------------------------------------------------
module tb_bipbip_dec_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic [63:0] req_tweak;
  logic [31:0] req_ct;
  logic        rsp_ready;
  logic        core_req_ready;
  logic        core_rsp_valid;
  logic [31:0] core_pt;

  logic        req_ready, rsp_valid, rsp_hit, core_req_valid;
  logic [31:0] rsp_pt, core_ct;
  logic [63:0] core_tweak;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_req_ready, s_rsp_valid, s_rsp_hit, s_core_req_valid;
  logic [31:0] s_rsp_pt, s_core_ct;
  logic [63:0] s_core_tweak;
  logic [1:0]  s_hit_cnt, s_miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  localparam logic [63:0] TW0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] TW1 = 64'hFEED_FACE_0000_0001;

  always #5 clk = ~clk;

  bipbip_dec_cache #(.ENTRIES(4), .TWEAK_W(64), .BLOCK_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_tweak_i(req_tweak), .req_ct_i(req_ct),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_pt_o(rsp_pt), .rsp_hit_o(rsp_hit),
    .core_req_valid_o(core_req_valid), .core_req_ready_i(core_req_ready),
    .core_tweak_o(core_tweak), .core_ct_o(core_ct),
    .core_rsp_valid_i(core_rsp_valid), .core_pt_i(core_pt),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  bipbip_dec_cache #(.ENTRIES(4), .TWEAK_W(64), .BLOCK_W(32), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(s_req_ready),
    .req_tweak_i(req_tweak), .req_ct_i(req_ct),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_pt_o(s_rsp_pt), .rsp_hit_o(s_rsp_hit),
    .core_req_valid_o(s_core_req_valid), .core_req_ready_i(core_req_ready),
    .core_tweak_o(s_core_tweak), .core_ct_o(s_core_ct),
    .core_rsp_valid_i(core_rsp_valid), .core_pt_i(core_pt),
    .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plaintext the bench's core returns for a given ciphertext.
  function automatic logic [31:0] key_pt(input logic [31:0] ct);
    return ct ^ 32'hC0DE_0000;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, ".hit_cnt"},    hit_cnt,    exp_hits);
    check({tag, ".miss_cnt"},   miss_cnt,   exp_miss);
    check({tag, ".sat_hit"},    s_hit_cnt,  sat3(exp_hits));
    check({tag, ".sat_miss"},   s_miss_cnt, sat3(exp_miss));
  endtask

  // One complete lookup. pt is the plaintext the core returns on a miss, and
  // the plaintext expected from the cache on a hit.
  task automatic txn(input string tag, input logic [63:0] tw, input logic [31:0] ct,
                     input logic [31:0] pt, input bit exp_hit, input int core_stall,
                     input int rsp_stall, input bit flush_wait);
    bit ok;
    @(negedge clk);
    check({tag, ".req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_tweak = tw;
    req_ct    = ct;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".check_outs"}, {rsp_valid, core_req_valid, req_ready}, 3'b000);
    @(negedge clk);
    if (exp_hit) begin
      exp_hits++;
      check({tag, ".hit_rsp_valid"}, rsp_valid, 1'b1);
      check({tag, ".hit_no_core"}, core_req_valid, 1'b0);
    end else begin
      exp_miss++;
      check({tag, ".core_req_valid"}, core_req_valid, 1'b1);
      check({tag, ".core_tweak"}, core_tweak, tw);
      check({tag, ".core_ct"}, core_ct, ct);
      ok = 1'b1;
      for (int i = 0; i < core_stall; i++) begin
        @(negedge clk);
        ok &= core_req_valid && core_tweak == tw && core_ct == ct && !rsp_valid;
      end
      if (core_stall > 0) check({tag, ".core_stall_stable"}, ok, 1'b1);
      core_req_ready = 1'b1;
      @(negedge clk);
      core_req_ready = 1'b0;
      check({tag, ".wait_outs"}, {core_req_valid, rsp_valid}, 2'b00);
      if (flush_wait) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      core_rsp_valid = 1'b1;
      core_pt        = pt;
      @(negedge clk);
      core_rsp_valid = 1'b0;
      core_pt        = '0;
      check({tag, ".miss_rsp_valid"}, rsp_valid, 1'b1);
    end
    check({tag, ".rsp_hit"}, rsp_hit, exp_hit);
    check({tag, ".rsp_pt"}, rsp_pt, pt);
    check_counters(tag);
    ok = 1'b1;
    for (int i = 0; i < rsp_stall; i++) begin
      @(negedge clk);
      ok &= rsp_valid && rsp_pt == pt && rsp_hit == exp_hit && !req_ready;
    end
    if (rsp_stall > 0) check({tag, ".rsp_stall_stable"}, ok, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic flush_idle(input string tag);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check({tag, ".idle_ready"}, req_ready, 1'b1);
    check_counters(tag);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ".req_ready"},      req_ready,      1'b1);
    check({tag, ".rsp_valid"},      rsp_valid,      1'b0);
    check({tag, ".rsp_pt"},         rsp_pt,         32'h0);
    check({tag, ".rsp_hit"},        rsp_hit,        1'b0);
    check({tag, ".core_req_valid"}, core_req_valid, 1'b0);
    check({tag, ".core_tweak"},     core_tweak,     64'h0);
    check({tag, ".core_ct"},        core_ct,        32'h0);
    check({tag, ".hit_cnt"},        hit_cnt,        16'h0);
    check({tag, ".miss_cnt"},       miss_cnt,       16'h0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_tweak = '0; req_ct = '0;
    rsp_ready = 1'b0; core_req_ready = 1'b0; core_rsp_valid = 1'b0; core_pt = '0;
    #3;
    check_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss, then hit on the same pair.
    txn("cold_miss", TW0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 0, 0, 1'b0);
    txn("warm_hit",  TW0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 0, 0, 1'b0);

    // Flush in IDLE invalidates both cached pairs.
    txn("fill_b",    TW1, 32'h0000_0100, key_pt(32'h100), 1'b0, 0, 0, 1'b0);
    flush_idle("flush_idle");
    txn("flush_rpA", TW0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 0, 0, 1'b0);
    txn("flush_rpB", TW1, 32'h0000_0100, key_pt(32'h100), 1'b0, 0, 0, 1'b0);

    // LRU: fill 1..4, touch 1, miss 5 evicts 2.
    flush_idle("flush_lru");
    for (int c = 1; c <= 4; c++)
      txn("lru_fill", TW1, 32'(c), key_pt(32'(c)), 1'b0, 0, 0, 1'b0);
    txn("lru_hit1",   TW1, 32'd1, key_pt(32'd1), 1'b1, 0, 0, 1'b0);
    txn("lru_miss5",  TW1, 32'd5, key_pt(32'd5), 1'b0, 0, 0, 1'b0);
    txn("lru_rp2",    TW1, 32'd2, key_pt(32'd2), 1'b0, 0, 0, 1'b0);
    txn("lru_rp1",    TW1, 32'd1, key_pt(32'd1), 1'b1, 0, 0, 1'b0);

    // Flush while waiting on the core: response delivered, not cached.
    txn("flush_wait", TW0, 32'h0000_0777, key_pt(32'h777), 1'b0, 0, 0, 1'b1);
    txn("fw_replay",  TW0, 32'h0000_0777, key_pt(32'h777), 1'b0, 0, 0, 1'b0);

    // Backpressure on both the core request and the response.
    txn("backpress",  TW0, 32'h0000_0888, key_pt(32'h888), 1'b0, 5, 4, 1'b0);
    txn("bp_hit",     TW0, 32'h0000_0888, key_pt(32'h888), 1'b1, 0, 0, 1'b0);

    // Reset while in ISSUE.
    @(negedge clk);
    req_valid = 1'b1; req_tweak = TW1; req_ct = 32'h0000_0999;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_issue.in_issue", core_req_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outs("rst_issue");
    @(negedge clk);
    rst_n = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
    txn("post_rst",   TW0, 32'h0000_0888, key_pt(32'h888), 1'b0, 0, 0, 1'b0);

    // Five hits: CNT_W=2 copy saturates at 3.
    for (int k = 0; k < 5; k++)
      txn("sat_hit", TW0, 32'h0000_0888, key_pt(32'h888), 1'b1, 0, 0, 1'b0);
    check("sat.final_hit", s_hit_cnt, 2'd3);
    check("main.final_hit", hit_cnt, 16'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bipbip_dec_cache
